// File: rtl/noc_pkg.sv
// Shared definitions for the NoC output-port slice: default widths, flit-type
// codes and the arbiter state type.
package noc_pkg;

   localparam int DEF_FLIT_W = 12;
   localparam int DEF_TYPE_W = 2;
   localparam int DEF_MOD_W  = DEF_FLIT_W + DEF_TYPE_W;

   localparam logic [1:0] FT_IDLE = 2'b00;
   localparam logic [1:0] FT_HEAD = 2'b01;
   localparam logic [1:0] FT_BODY = 2'b10;
   localparam logic [1:0] FT_TAIL = 2'b11;

   typedef enum logic {ARB_IDLE, ARB_LOCKED} arbState_e;

endpackage

// File: rtl/noc_output_port_rr_if.sv
// Link bundle of the output port: tagged flits and block lines towards the
// input ports, valid/ready payload towards the downstream link.
interface noc_output_port_rr_if
   import noc_pkg::*;
#(
   parameter int FLIT_W = DEF_FLIT_W,
   parameter int TYPE_W = DEF_TYPE_W,
   parameter int NUM_IN = 4
);
   localparam int MOD_W = FLIT_W + TYPE_W;

   logic [NUM_IN*MOD_W-1:0] in_flit;
   logic [NUM_IN-1:0]       in_block;
   logic [FLIT_W-1:0]       out_flit;
   logic                    out_last;
   logic                    out_valid;
   logic                    out_ready;

   modport master (
      output in_flit, out_ready,
      input  in_block, out_flit, out_last, out_valid
   );

   modport slave (
      input  in_flit, out_ready,
      output in_block, out_flit, out_last, out_valid
   );

endinterface

// File: rtl/noc_flit_fifo.sv
// Synchronous flit FIFO (payload + last bit) with full/empty flags; the head
// reads as zero while empty so the link outputs are clean after reset.
module noc_flit_fifo #(
   parameter int W     = 13,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] pushData,
   input  logic         pop,
   output logic [W-1:0] popData,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wrPtr;
   logic [AW-1:0] rdPtr;
   logic [AW:0]   count;
   logic          doPush;
   logic          doPop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign doPush  = push && !full;
   assign doPop   = pop && !empty;
   assign popData = empty ? '0 : mem[rdPtr];

   always_ff @(posedge clk) begin
      if (doPush) mem[wrPtr] <= pushData;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + 1'b1;
         if (doPop)  rdPtr <= rdPtr + 1'b1;
         case ({doPush, doPop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/noc_output_port_rr.sv
// Router output port: round-robin packet arbitration with wormhole locking into
// an output FIFO. Optional counters under NOC_OUTPORT_STATS_EN.
//
// state      | meaning
// ARB_IDLE   | no packet owns the link; heads compete round-robin from rrPtr
// ARB_LOCKED | owner's flits pass until its tail is pushed; others are blocked
module noc_output_port_rr
   import noc_pkg::*;
#(
   parameter int FLIT_W = DEF_FLIT_W,
   parameter int TYPE_W = DEF_TYPE_W,
   parameter int NUM_IN = 4,
   parameter int DEPTH  = 4
) (
   input logic                clk,
   input logic                rst_n,
   noc_output_port_rr_if.slave port
`ifdef NOC_OUTPORT_STATS_EN
   ,
   output logic [15:0]        pkt_count,
   output logic [7:0]         err_count
`endif
);
   localparam int MOD_W = FLIT_W + TYPE_W;
   localparam int PW    = $clog2(NUM_IN);

   arbState_e         state;
   logic [PW-1:0]     owner;
   logic [PW-1:0]     rrPtr;
   logic [TYPE_W-1:0] chType [NUM_IN];
   logic [FLIT_W-1:0] chData [NUM_IN];
   logic              grantFound;
   logic [PW-1:0]     grantIdx;
   logic [NUM_IN-1:0] inBlock;
   logic              pushEn;
   logic [FLIT_W-1:0] pushData;
   logic              pushLast;
   logic              protoErr;
   logic              fifoFull;
   logic              fifoEmpty;
   logic [FLIT_W:0]   fifoHead;

   function automatic int rrIdx(input logic [PW-1:0] base, input int k);
      return (int'(base) + k) % NUM_IN;
   endfunction

   always_comb begin
      for (int i = 0; i < NUM_IN; i++) begin
         chData[i] = port.in_flit[i*MOD_W +: FLIT_W];
         chType[i] = port.in_flit[i*MOD_W + FLIT_W +: TYPE_W];
      end
   end

   always_comb begin
      grantFound = 1'b0;
      grantIdx   = '0;
      for (int k = 0; k < NUM_IN; k++) begin
         if (!grantFound && chType[rrIdx(rrPtr, k)] == TYPE_W'(FT_HEAD)) begin
            grantFound = 1'b1;
            grantIdx   = PW'(rrIdx(rrPtr, k));
         end
      end
   end

   // Block decisions look only at the current full flag; a same-cycle pop
   // does not open a slot for the inputs.
   always_comb begin
      inBlock  = '0;
      pushEn   = 1'b0;
      pushData = '0;
      pushLast = 1'b0;
      protoErr = 1'b0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (chType[i] != TYPE_W'(FT_IDLE)) begin
            if (fifoFull) begin
               inBlock[i] = 1'b1;
            end else if (state == ARB_IDLE) begin
               if (chType[i] == TYPE_W'(FT_HEAD))
                  inBlock[i] = !(grantFound && grantIdx == PW'(i));
               else
                  protoErr = 1'b1;
            end else begin
               inBlock[i] = (PW'(i) != owner);
            end
         end
      end
      if (!fifoFull) begin
         if (state == ARB_IDLE) begin
            if (grantFound) begin
               pushEn   = 1'b1;
               pushData = chData[grantIdx];
            end
         end else if (chType[owner] != TYPE_W'(FT_IDLE)) begin
            pushEn   = 1'b1;
            pushData = chData[owner];
            pushLast = (chType[owner] == TYPE_W'(FT_TAIL));
            if (chType[owner] == TYPE_W'(FT_HEAD)) protoErr = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ARB_IDLE;
         owner <= '0;
         rrPtr <= '0;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (pushEn) begin
                  owner <= grantIdx;
                  state <= ARB_LOCKED;
               end
            end
            ARB_LOCKED: begin
               if (pushEn && pushLast) begin
                  state <= ARB_IDLE;
                  rrPtr <= (owner == PW'(NUM_IN-1)) ? '0 : owner + PW'(1);
               end
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

   noc_flit_fifo #(
      .W     (FLIT_W + 1),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (pushEn),
      .pushData ({pushLast, pushData}),
      .pop      (port.out_ready),
      .popData  (fifoHead),
      .full     (fifoFull),
      .empty    (fifoEmpty)
   );

   assign port.in_block  = inBlock;
   assign port.out_flit  = fifoHead[FLIT_W-1:0];
   assign port.out_last  = fifoHead[FLIT_W];
   assign port.out_valid = !fifoEmpty;

`ifdef NOC_OUTPORT_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pkt_count <= '0;
         err_count <= '0;
      end else begin
         if (pushEn && pushLast && state == ARB_LOCKED) pkt_count <= pkt_count + 16'd1;
         if (protoErr && err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_noc_output_port_rr.sv
// Bench for noc_output_port_rr: directed scenarios plus random packet traffic,
// checked against a queue-based model of the port's arbitration rules.
module tb_noc_output_port_rr;
   import noc_pkg::*;

   localparam int FW = 12;
   localparam int TW = 2;
   localparam int NI = 4;
   localparam int DP = 4;
   localparam int MW = FW + TW;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   noc_output_port_rr_if #(.FLIT_W(FW), .TYPE_W(TW), .NUM_IN(NI)) ifc ();

`ifdef NOC_OUTPORT_STATS_EN
   logic [15:0] pktCount;
   logic [7:0]  errCount;
`endif

   noc_output_port_rr #(.FLIT_W(FW), .TYPE_W(TW), .NUM_IN(NI), .DEPTH(DP)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .port  (ifc.slave)
`ifdef NOC_OUTPORT_STATS_EN
      ,
      .pkt_count (pktCount),
      .err_count (errCount)
`endif
   );

   int nChecks = 0;
   int nFails  = 0;

   // reference model state
   bit            mLocked;
   int            mOwner;
   int            mRr;
   logic [FW:0]   mQ [$];
   int            mPkts;
   int            mErrs;
   int            mPops;

   logic [MW-1:0] drv [NI];
   bit            drvReady;
   logic [NI-1:0] expBlock;
   logic [NI-1:0] lastBlock;
   logic [FW-1:0] lastFlit;
   logic          lastLast;
   logic          lastValid;

   function automatic logic [MW-1:0] mk(input logic [1:0] t, input logic [FW-1:0] d);
      return {t, d};
   endfunction

   function automatic logic [1:0] ty(input logic [MW-1:0] f);
      return f[MW-1:FW];
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      assert (obs === exp) else begin
         nFails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      mLocked = 0; mOwner = 0; mRr = 0; mQ.delete(); mPkts = 0; mErrs = 0;
   endtask

   task automatic idleAll();
      for (int i = 0; i < NI; i++) drv[i] = mk(FT_IDLE, '0);
   endtask

   // Called at posedge+1: apply inputs, check at negedge, advance model at posedge.
   task automatic cycle();
      bit full;
      int grant;
      bit pushV;
      bit errThis;
      logic [FW:0] pushD;
      for (int i = 0; i < NI; i++) ifc.in_flit[i*MW +: MW] = drv[i];
      ifc.out_ready = drvReady;
      @(negedge clk);
      full = (mQ.size() == DP);
      grant = -1; pushV = 0; errThis = 0; pushD = '0; expBlock = '0;
      if (!mLocked)
         for (int k = 0; k < NI; k++)
            if (grant < 0 && ty(drv[(mRr + k) % NI]) == FT_HEAD) grant = (mRr + k) % NI;
      for (int i = 0; i < NI; i++) begin
         if (ty(drv[i]) != FT_IDLE) begin
            if (full) expBlock[i] = 1'b1;
            else if (!mLocked) begin
               if (ty(drv[i]) == FT_HEAD) expBlock[i] = (i != grant);
               else errThis = 1;
            end else expBlock[i] = (i != mOwner);
         end
      end
      if (!full) begin
         if (!mLocked && grant >= 0) begin
            pushV = 1; pushD = {1'b0, drv[grant][FW-1:0]};
         end else if (mLocked && ty(drv[mOwner]) != FT_IDLE) begin
            pushV = 1; pushD = {ty(drv[mOwner]) == FT_TAIL, drv[mOwner][FW-1:0]};
            if (ty(drv[mOwner]) == FT_HEAD) errThis = 1;
         end
      end
      lastBlock = ifc.in_block; lastFlit = ifc.out_flit;
      lastLast = ifc.out_last; lastValid = ifc.out_valid;
      check("in_block", ifc.in_block, expBlock);
      check("out_valid", ifc.out_valid, mQ.size() > 0);
      check("out_flit", ifc.out_flit, mQ.size() > 0 ? mQ[0][FW-1:0] : '0);
      check("out_last", ifc.out_last, mQ.size() > 0 ? mQ[0][FW] : 1'b0);
`ifdef NOC_OUTPORT_STATS_EN
      check("pkt_count", pktCount, mPkts % 65536);
      check("err_count", errCount, mErrs);
`endif
      @(posedge clk);
      if (drvReady && mQ.size() > 0) begin
         void'(mQ.pop_front());
         mPops++;
      end
      if (pushV) begin
         mQ.push_back(pushD);
         if (!mLocked) begin
            mLocked = 1; mOwner = grant;
         end else if (pushD[FW]) begin
            mLocked = 0; mRr = (mOwner + 1) % NI; mPkts++;
         end
      end
      if (errThis && mErrs < 255) mErrs++;
      #1;
   endtask

   task automatic doReset();
      idleAll();
      for (int i = 0; i < NI; i++) ifc.in_flit[i*MW +: MW] = drv[i];
      rst_n = 1'b0;
      #1;
      check("rst_out_valid", ifc.out_valid, 1'b0);
      check("rst_out_flit", ifc.out_flit, '0);
      check("rst_in_block", ifc.in_block, '0);
      #2;
      rst_n = 1'b1;
      modelReset();
      @(posedge clk);
      #1;
   endtask

   logic [MW-1:0] pkt3 [6];
   logic [MW-1:0] gq [NI][$];
   int idx;
   int popBase;
   bit drove [NI];

   initial begin
      modelReset();
      mPops = 0;
      idleAll();
      drvReady = 1;
      for (int i = 0; i < NI; i++) ifc.in_flit[i*MW +: MW] = drv[i];
      ifc.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset_out_valid", ifc.out_valid, 1'b0);
      check("reset_in_block", ifc.in_block, 4'b0000);
      check("reset_out_last", ifc.out_last, 1'b0);
      rst_n = 1'b1;

      // single 3-flit packet on channel 0
      drv[0] = mk(FT_HEAD, 12'h92B); cycle();
      drv[0] = mk(FT_BODY, 12'h0F0); cycle();
      check("t1_flit1", lastFlit, 12'h92B);
      drv[0] = mk(FT_TAIL, 12'h1AB); cycle();
      check("t1_flit2", lastFlit, 12'h0F0);
      check("t1_last2", lastLast, 1'b0);
      idleAll(); cycle();
      check("t1_flit3", lastFlit, 12'h1AB);
      check("t1_last3", lastLast, 1'b1);
      cycle();

      // contention between channels 1 and 2 from rr_ptr=0
      doReset();
      drv[1] = mk(FT_HEAD, 12'h111); drv[2] = mk(FT_HEAD, 12'h222); cycle();
      check("t2_block_a", lastBlock, 4'b0100);
      drv[1] = mk(FT_BODY, 12'h112); cycle();
      check("t2_block_b", lastBlock, 4'b0100);
      drv[1] = mk(FT_TAIL, 12'h113); cycle();
      check("t2_block_c", lastBlock, 4'b0100);
      drv[1] = mk(FT_IDLE, '0); drv[0] = mk(FT_HEAD, 12'h0A0); cycle();
      check("t2_rr_grant2", lastBlock, 4'b0001);
      drv[2] = mk(FT_TAIL, 12'h223); cycle();
      drv[2] = mk(FT_IDLE, '0); cycle();
      check("t2_ch0_granted", lastBlock, 4'b0000);
      drv[0] = mk(FT_TAIL, 12'h0A1); cycle();
      idleAll(); repeat (3) cycle();

      // backpressure: 6-flit packet on channel 3 with out_ready low
      pkt3[0] = mk(FT_HEAD, 12'h301);
      for (int k = 1; k < 5; k++) pkt3[k] = mk(FT_BODY, 12'h300 + 12'(k + 1));
      pkt3[5] = mk(FT_TAIL, 12'h306);
      idx = 0;
      drvReady = 0;
      for (int c = 0; c < 8; c++) begin
         drv[3] = (idx < 6) ? pkt3[idx] : mk(FT_IDLE, '0);
         cycle();
         if (idx < 6 && !expBlock[3]) idx++;
      end
      check("t3_accepted", idx, 4);
      check("t3_block", lastBlock, 4'b1000);
      popBase = mPops;
      drvReady = 1;
      for (int c = 0; c < 20 && (idx < 6 || mQ.size() > 0); c++) begin
         drv[3] = (idx < 6) ? pkt3[idx] : mk(FT_IDLE, '0);
         cycle();
         if (idx < 6 && !expBlock[3]) idx++;
      end
      check("t3_all_sent", idx, 6);
      check("t3_drained", mPops - popBase, 6);
      idleAll(); cycle();

      // stray body in IDLE is discarded
      drv[0] = mk(FT_BODY, 12'h055); cycle();
      check("t4_block", lastBlock, 4'b0000);
      idleAll(); cycle();
      check("t4_no_push", lastValid, 1'b0);
`ifdef NOC_OUTPORT_STATS_EN
      check("t4_err_count", errCount, 8'd1);
`endif

      // reset in the middle of a packet
      drvReady = 0;
      drv[1] = mk(FT_HEAD, 12'h5A0); cycle();
      drv[1] = mk(FT_BODY, 12'h5A1); cycle();
      doReset();
      drvReady = 1;
      drv[1] = mk(FT_BODY, 12'h5A2); cycle();
      drv[1] = mk(FT_TAIL, 12'h5A3); cycle();
      idleAll(); cycle();
      check("t5_discarded", lastValid, 1'b0);
      drv[2] = mk(FT_HEAD, 12'h6B0); cycle();
      drv[2] = mk(FT_TAIL, 12'h6B1); cycle();
      check("t5_new_head", lastFlit, 12'h6B0);
      idleAll(); repeat (2) cycle();

      // three packets from rotating channels
      doReset();
      for (int p = 0; p < 3; p++) begin
         drv[p] = mk(FT_HEAD, 12'h700 + 12'(p)); cycle();
         drv[p] = mk(FT_TAIL, 12'h7F0 + 12'(p)); cycle();
         idleAll();
      end
      repeat (2) cycle();
`ifdef NOC_OUTPORT_STATS_EN
      check("t6_pkt_count", pktCount, 16'd3);
      check("t6_err_count", errCount, 8'd0);
`endif

      // random packet traffic with per-channel holding generators
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < NI; i++) begin
            if (gq[i].size() == 0 && $urandom_range(0, 3) == 0) begin
               if ($urandom_range(0, 15) == 0) gq[i].push_back(mk(FT_BODY, 12'($urandom)));
               else begin
                  gq[i].push_back(mk(FT_HEAD, 12'($urandom)));
                  for (int b = 0; b < int'($urandom_range(0, 3)); b++)
                     gq[i].push_back(mk($urandom_range(0, 7) == 0 ? FT_IDLE : FT_BODY, 12'($urandom)));
                  gq[i].push_back(mk(FT_TAIL, 12'($urandom)));
               end
            end
            drove[i] = (gq[i].size() > 0);
            drv[i] = drove[i] ? gq[i][0] : mk(FT_IDLE, '0);
         end
         drvReady = ($urandom_range(0, 9) < 7);
         cycle();
         for (int i = 0; i < NI; i++)
            if (drove[i] && !expBlock[i]) void'(gq[i].pop_front());
      end
      idleAll();
      drvReady = 1;
      repeat (DP + 2) cycle();
      check("final_empty", lastValid, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
